// File: rtl/brg_xcel_network_tx_gen.sv
// Generic master-side network TX endpoint: issues load/store packets, reserves response space,
// queues load data, supports fence. Optional stats counters under BRG_XCEL_TX_STATS_EN.
module brg_xcel_network_tx_gen #(
  parameter int unsigned data_width_p      = 32,
  parameter int unsigned addr_width_p      = 28,
  parameter int unsigned x_cord_width_p    = 6,
  parameter int unsigned y_cord_width_p    = 5,
  parameter int unsigned max_out_credits_p = 16,
  parameter int unsigned max_out_loads_p   = 8,
  parameter int unsigned resp_fifo_els_p   = 4,
  // Packet layout, MSB to LSB: addr, op, op_ex, reg_id, payload, src_y, src_x, y_cord, x_cord
  localparam int unsigned packet_width_lp = addr_width_p + 2 + data_width_p / 8 + 5
                                          + data_width_p + 2 * (x_cord_width_p + y_cord_width_p),
  localparam int unsigned cred_width_lp   = $clog2(max_out_credits_p + 1)
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic [x_cord_width_p-1:0]  my_x_i,
  input  logic [y_cord_width_p-1:0]  my_y_i,
  output logic                       v_o,
  output logic [packet_width_lp-1:0] packet_o,
  input  logic                       ready_i,
  input  logic [cred_width_lp-1:0]   credits_i,
  input  logic [data_width_p-1:0]    returned_data_i,
  input  logic [4:0]                 returned_reg_id_i,
  input  logic [1:0]                 returned_pkt_type_i,
  input  logic                       returned_v_i,
  output logic                       returned_yumi_o,
  input  logic                       req_v_i,
  input  logic                       req_store_i,
  input  logic [addr_width_p-1:0]    req_addr_i,
  input  logic [data_width_p-1:0]    req_data_i,
  input  logic [data_width_p/8-1:0]  req_mask_i,
  input  logic [4:0]                 req_reg_id_i,
  input  logic [x_cord_width_p-1:0]  req_x_i,
  input  logic [y_cord_width_p-1:0]  req_y_i,
  output logic                       req_ready_o,
  output logic                       resp_v_o,
  output logic [data_width_p-1:0]    resp_data_o,
  output logic [4:0]                 resp_reg_id_o,
  input  logic                       resp_yumi_i,
  input  logic                       fence_i,
  output logic                       fence_done_o,
`ifdef BRG_XCEL_TX_STATS_EN
  output logic [31:0]                stat_loads_o,
  output logic [31:0]                stat_stores_o,
  output logic [31:0]                stat_stalls_o,
`endif
  output logic [cred_width_lp-1:0]   outstanding_o
);

  localparam int unsigned MaskW   = data_width_p / 8;
  localparam int unsigned LoadsW  = $clog2(max_out_loads_p + 1);
  localparam int unsigned FifoCW  = $clog2(resp_fifo_els_p + 1);
  localparam int unsigned PtrW    = $clog2(resp_fifo_els_p);
  localparam int unsigned EntryW  = data_width_p + 5;

  localparam logic [1:0] OpRemoteLoad  = 2'd0;
  localparam logic [1:0] OpRemoteStore = 2'd1;
  localparam logic [1:0] RetIntWb      = 2'd1;
  localparam logic [1:0] RetFloatWb    = 2'd2;
  // load_info: part_sel[1:0], is_hex_op, is_byte_op, is_unsigned_op(bit 4), icache_fetch, float_wb
  localparam logic [data_width_p-1:0] LoadInfo = data_width_p'(32'h10);

  typedef enum logic [0:0] {StReady, StFence} state_e;

  state_e                    state_q, state_d;
  logic [cred_width_lp-1:0]  outstanding_q, outstanding_d;
  logic [LoadsW-1:0]         loads_out_q, loads_out_d;
  logic [FifoCW-1:0]         fifo_cnt_q, fifo_cnt_d;
  logic [PtrW-1:0]           wptr_q, wptr_d, rptr_q, rptr_d;
  logic [EntryW-1:0]         mem_q [resp_fifo_els_p];

  logic issue_ok, fire, load_fire, ret_wb, push, pop, drained;

  // A load may issue only if its response is guaranteed a FIFO slot.
  always_comb begin
    issue_ok = !reset_i && (state_q == StReady) && (credits_i != '0) &&
               (req_store_i ||
                ((32'(loads_out_q) < max_out_loads_p) &&
                 (32'(loads_out_q) + 32'(fifo_cnt_q) < resp_fifo_els_p)));
  end

  assign v_o             = req_v_i & issue_ok;
  assign req_ready_o     = ready_i & issue_ok;
  assign fire            = v_o & ready_i;
  assign load_fire       = fire & ~req_store_i;
  assign returned_yumi_o = returned_v_i & ~reset_i;
  assign ret_wb          = returned_yumi_o &
                           ((returned_pkt_type_i == RetIntWb) || (returned_pkt_type_i == RetFloatWb));
  assign push            = ret_wb;
  assign pop             = resp_yumi_i & resp_v_o;
  assign drained         = (outstanding_q == '0) && (loads_out_q == '0);

  assign packet_o = {req_addr_i,
                     req_store_i ? OpRemoteStore : OpRemoteLoad,
                     req_store_i ? req_mask_i : {MaskW{1'b1}},
                     req_reg_id_i,
                     req_store_i ? req_data_i : LoadInfo,
                     my_y_i, my_x_i, req_y_i, req_x_i};

  always_comb begin
    state_d      = state_q;
    fence_done_o = 1'b0;
    unique case (state_q)
      StReady: if (fence_i) state_d = StFence;
      StFence: if (drained) begin
        fence_done_o = 1'b1;
        state_d      = StReady;
      end
      default: state_d = StReady;
    endcase
  end

  always_comb begin
    outstanding_d = outstanding_q + cred_width_lp'(fire) - cred_width_lp'(returned_yumi_o);
    loads_out_d   = loads_out_q + LoadsW'(load_fire) - LoadsW'(ret_wb);
    fifo_cnt_d    = fifo_cnt_q + FifoCW'(push) - FifoCW'(pop);
    wptr_d        = wptr_q;
    rptr_d        = rptr_q;
    if (push) wptr_d = (wptr_q == PtrW'(resp_fifo_els_p - 1)) ? '0 : wptr_q + 1'b1;
    if (pop)  rptr_d = (rptr_q == PtrW'(resp_fifo_els_p - 1)) ? '0 : rptr_q + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q       <= StReady;
      outstanding_q <= '0;
      loads_out_q   <= '0;
      fifo_cnt_q    <= '0;
      wptr_q        <= '0;
      rptr_q        <= '0;
    end else begin
      state_q       <= state_d;
      outstanding_q <= outstanding_d;
      loads_out_q   <= loads_out_d;
      fifo_cnt_q    <= fifo_cnt_d;
      wptr_q        <= wptr_d;
      rptr_q        <= rptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem_q[wptr_q] <= {returned_data_i, returned_reg_id_i};
  end

  assign resp_v_o      = (fifo_cnt_q != '0);
  assign resp_data_o   = mem_q[rptr_q][EntryW-1:5];
  assign resp_reg_id_o = mem_q[rptr_q][4:0];
  assign outstanding_o = outstanding_q;

`ifdef BRG_XCEL_TX_STATS_EN
  logic [31:0] stat_loads_q, stat_stores_q, stat_stalls_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      stat_loads_q  <= '0;
      stat_stores_q <= '0;
      stat_stalls_q <= '0;
    end else begin
      if (load_fire && stat_loads_q != '1)             stat_loads_q  <= stat_loads_q + 1'b1;
      if (fire && req_store_i && stat_stores_q != '1)  stat_stores_q <= stat_stores_q + 1'b1;
      if (req_v_i && !req_ready_o && stat_stalls_q != '1)
        stat_stalls_q <= stat_stalls_q + 1'b1;
    end
  end

  assign stat_loads_o  = stat_loads_q;
  assign stat_stores_o = stat_stores_q;
  assign stat_stalls_o = stat_stalls_q;
`endif

`ifndef SYNTHESIS
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      assert (!(resp_yumi_i && !resp_v_o))
        else $error("resp_yumi_i asserted with empty response FIFO");
      assert (!(push && !pop && (32'(fifo_cnt_q) == resp_fifo_els_p)))
        else $error("response FIFO overflow");
      assert (!(returned_v_i && (outstanding_q == '0) && !fire))
        else $error("outstanding counter underflow");
    end
  end
`endif

endmodule

// File: tb/tb_brg_xcel_network_tx_gen.sv
// Directed self-checking bench for brg_xcel_network_tx_gen (default parameters, stats disabled).
module tb_brg_xcel_network_tx_gen;

  localparam int PW = 93;

  logic        clk = 1'b0;
  logic        reset_i;
  logic [5:0]  my_x_i = 6'd3;
  logic [4:0]  my_y_i = 5'd4;
  logic        v_o;
  logic [PW-1:0] packet_o;
  logic        ready_i;
  logic [4:0]  credits_i;
  logic [31:0] returned_data_i;
  logic [4:0]  returned_reg_id_i;
  logic [1:0]  returned_pkt_type_i;
  logic        returned_v_i;
  logic        returned_yumi_o;
  logic        req_v_i, req_store_i;
  logic [27:0] req_addr_i;
  logic [31:0] req_data_i;
  logic [3:0]  req_mask_i;
  logic [4:0]  req_reg_id_i;
  logic [5:0]  req_x_i;
  logic [4:0]  req_y_i;
  logic        req_ready_o;
  logic        resp_v_o;
  logic [31:0] resp_data_o;
  logic [4:0]  resp_reg_id_o;
  logic        resp_yumi_i;
  logic        fence_i;
  logic        fence_done_o;
  logic [4:0]  outstanding_o;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  brg_xcel_network_tx_gen dut (
    .clk_i(clk), .reset_i(reset_i), .my_x_i(my_x_i), .my_y_i(my_y_i),
    .v_o(v_o), .packet_o(packet_o), .ready_i(ready_i), .credits_i(credits_i),
    .returned_data_i(returned_data_i), .returned_reg_id_i(returned_reg_id_i),
    .returned_pkt_type_i(returned_pkt_type_i), .returned_v_i(returned_v_i),
    .returned_yumi_o(returned_yumi_o), .req_v_i(req_v_i), .req_store_i(req_store_i),
    .req_addr_i(req_addr_i), .req_data_i(req_data_i), .req_mask_i(req_mask_i),
    .req_reg_id_i(req_reg_id_i), .req_x_i(req_x_i), .req_y_i(req_y_i),
    .req_ready_o(req_ready_o), .resp_v_o(resp_v_o), .resp_data_o(resp_data_o),
    .resp_reg_id_o(resp_reg_id_o), .resp_yumi_i(resp_yumi_i), .fence_i(fence_i),
    .fence_done_o(fence_done_o), .outstanding_o(outstanding_o)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected packet: {addr, op, op_ex, reg_id, payload, src_y=4, src_x=3, y, x}
  function automatic logic [PW-1:0] pkt(input bit st, input logic [27:0] a, input logic [3:0] m,
                                        input logic [4:0] r, input logic [31:0] d,
                                        input logic [5:0] x, input logic [4:0] y);
    return {a, st ? 2'd1 : 2'd0, st ? m : 4'hF, r, st ? d : 32'h10, 5'd4, 6'd3, y, x};
  endfunction

  task automatic set_req(input bit st, input logic [27:0] a, input logic [4:0] r,
                         input logic [31:0] d, input logic [3:0] m);
    req_v_i = 1'b1; req_store_i = st; req_addr_i = a; req_reg_id_i = r;
    req_data_i = d; req_mask_i = m;
  endtask

  task automatic set_ret(input logic [1:0] t, input logic [31:0] d, input logic [4:0] r);
    returned_v_i = 1'b1; returned_pkt_type_i = t; returned_data_i = d; returned_reg_id_i = r;
  endtask

  initial begin
    reset_i = 1'b1; ready_i = 1'b1; credits_i = 5'd16; returned_v_i = 1'b0;
    returned_data_i = '0; returned_reg_id_i = '0; returned_pkt_type_i = 2'd0;
    resp_yumi_i = 1'b0; fence_i = 1'b0; req_x_i = 6'd2; req_y_i = 5'd1;
    set_req(1'b0, 28'h100, 5'd1, 32'h0, 4'h0);
    tick(); tick();
    chk("rst_v_o", v_o, 1'b0);
    chk("rst_req_ready", req_ready_o, 1'b0);
    chk("rst_resp_v", resp_v_o, 1'b0);
    chk("rst_outstanding", outstanding_o, 5'd0);
    chk("rst_fence_done", fence_done_o, 1'b0);
    chk("rst_returned_yumi", returned_yumi_o, 1'b0);
    reset_i = 1'b0;

    // three back-to-back loads to (2,1)
    for (int i = 0; i < 3; i++) begin
      set_req(1'b0, 28'h100 + 28'(i), 5'(i + 1), 32'h0, 4'h0);
      #1;
      chk("ld_v_o", v_o, 1'b1);
      chk("ld_ready", req_ready_o, 1'b1);
      chk("ld_packet", packet_o, pkt(1'b0, 28'h100 + 28'(i), 4'h0, 5'(i + 1), 32'h0, 6'd2, 5'd1));
      tick();
    end
    req_v_i = 1'b0; #1;
    chk("ld3_outstanding", outstanding_o, 5'd3);
    chk("ld3_resp_v", resp_v_o, 1'b0);
    for (int i = 0; i < 3; i++) begin
      set_ret(2'd1, 32'hA + 32'(i), 5'(i + 1));
      #1;
      chk("ret_yumi", returned_yumi_o, 1'b1);
      tick();
    end
    returned_v_i = 1'b0; #1;
    chk("ret_outstanding", outstanding_o, 5'd0);
    resp_yumi_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("pop_data", resp_data_o, 32'hA + 32'(i));
      chk("pop_reg", resp_reg_id_o, 5'(i + 1));
      tick();
    end
    resp_yumi_i = 1'b0; #1;
    chk("pop_empty", resp_v_o, 1'b0);

    // fill the FIFO, then a load must stall while a store proceeds
    for (int i = 0; i < 4; i++) begin
      set_req(1'b0, 28'h200 + 28'(i), 5'(4 + i), 32'h0, 4'h0);
      tick();
    end
    req_v_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      set_ret(2'd1, 32'h10 + 32'(i), 5'(4 + i));
      tick();
    end
    returned_v_i = 1'b0;
    set_req(1'b0, 28'h210, 5'd8, 32'h0, 4'h0); #1;
    chk("full_ld_ready", req_ready_o, 1'b0);
    chk("full_ld_v", v_o, 1'b0);
    req_store_i = 1'b1; req_data_i = 32'h1; req_mask_i = 4'hF; #1;
    chk("full_st_ready", req_ready_o, 1'b1);
    tick();
    req_store_i = 1'b0; #1;
    chk("full_ld_ready2", req_ready_o, 1'b0);
    resp_yumi_i = 1'b1; #1;
    chk("full_head", resp_data_o, 32'h10);
    tick();
    resp_yumi_i = 1'b0; #1;
    chk("after_pop_ready", req_ready_o, 1'b1);
    chk("after_pop_head", resp_data_o, 32'h11);
    tick();
    req_v_i = 1'b0; #1;
    chk("mix_outstanding", outstanding_o, 5'd2);
    set_ret(2'd0, 32'h0, 5'd0);
    tick();
    returned_v_i = 1'b0; #1;
    chk("credit_outstanding", outstanding_o, 5'd1);
    chk("credit_head", resp_data_o, 32'h11);
    set_ret(2'd1, 32'h20, 5'd8);
    tick();
    returned_v_i = 1'b0;
    resp_yumi_i = 1'b1; #1;
    chk("drain0", {resp_data_o, resp_reg_id_o}, {32'h11, 5'd5}); tick();
    chk("drain1", {resp_data_o, resp_reg_id_o}, {32'h12, 5'd6}); tick();
    chk("drain2", {resp_data_o, resp_reg_id_o}, {32'h13, 5'd7}); tick();
    chk("drain3", {resp_data_o, resp_reg_id_o}, {32'h20, 5'd8}); tick();
    resp_yumi_i = 1'b0; #1;
    chk("drain_empty", resp_v_o, 1'b0);

    // credits gate issue; store packet format
    credits_i = 5'd0; req_x_i = 6'd1; req_y_i = 5'd2;
    set_req(1'b1, 28'h55, 5'd0, 32'hDEADBEEF, 4'b0011); #1;
    chk("nocred_v", v_o, 1'b0);
    chk("nocred_ready", req_ready_o, 1'b0);
    tick();
    credits_i = 5'd1; #1;
    chk("cred_v", v_o, 1'b1);
    chk("st_packet", packet_o, pkt(1'b1, 28'h55, 4'b0011, 5'd0, 32'hDEADBEEF, 6'd1, 5'd2));
    tick();
    req_v_i = 1'b0; credits_i = 5'd16; #1;
    chk("st_outstanding", outstanding_o, 5'd1);
    set_ret(2'd0, 32'h0, 5'd0);
    tick();
    returned_v_i = 1'b0; #1;
    chk("st_ret_outstanding", outstanding_o, 5'd0);
    chk("st_ret_fifo", resp_v_o, 1'b0);

    // fence with two loads in flight
    req_x_i = 6'd2; req_y_i = 5'd1;
    set_req(1'b0, 28'h300, 5'd10, 32'h0, 4'h0);
    tick();
    set_req(1'b0, 28'h301, 5'd11, 32'h0, 4'h0);
    fence_i = 1'b1; #1;
    chk("fence_entry_ready", req_ready_o, 1'b1);
    tick();
    fence_i = 1'b0;
    set_req(1'b0, 28'h302, 5'd12, 32'h0, 4'h0); #1;
    chk("fence_ready", req_ready_o, 1'b0);
    chk("fence_v", v_o, 1'b0);
    chk("fence_done_early", fence_done_o, 1'b0);
    chk("fence_outstanding", outstanding_o, 5'd2);
    set_ret(2'd1, 32'h30, 5'd10);
    tick();
    chk("fence_done_mid", fence_done_o, 1'b0);
    set_ret(2'd2, 32'h31, 5'd11);
    tick();
    returned_v_i = 1'b0; #1;
    chk("fence_done_pulse", fence_done_o, 1'b1);
    tick();
    chk("fence_done_once", fence_done_o, 1'b0);
    chk("fence_back_ready", req_ready_o, 1'b1);
    req_v_i = 1'b0;
    resp_yumi_i = 1'b1; #1;
    chk("fence_resp0", {resp_data_o, resp_reg_id_o}, {32'h30, 5'd10}); tick();
    chk("fence_resp1", {resp_data_o, resp_reg_id_o}, {32'h31, 5'd11}); tick();
    resp_yumi_i = 1'b0;

    // fence when already drained pulses on the following cycle
    fence_i = 1'b1; #1;
    chk("fence_idle_nopulse", fence_done_o, 1'b0);
    tick();
    fence_i = 1'b0; #1;
    chk("fence_idle_pulse", fence_done_o, 1'b1);
    tick();
    chk("fence_idle_after", fence_done_o, 1'b0);

    // reset with 3 outstanding and 2 queued responses
    for (int i = 0; i < 2; i++) begin
      set_req(1'b0, 28'h400 + 28'(i), 5'(13 + i), 32'h0, 4'h0);
      tick();
    end
    req_v_i = 1'b0;
    for (int i = 0; i < 2; i++) begin
      set_ret(2'd1, 32'h40 + 32'(i), 5'(13 + i));
      tick();
    end
    returned_v_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_req(1'b1, 28'h500 + 28'(i), 5'd0, 32'(i), 4'hF);
      tick();
    end
    req_v_i = 1'b0; #1;
    chk("pre_rst_outstanding", outstanding_o, 5'd3);
    chk("pre_rst_resp_v", resp_v_o, 1'b1);
    reset_i = 1'b1;
    tick();
    reset_i = 1'b0; #1;
    chk("mid_rst_outstanding", outstanding_o, 5'd0);
    chk("mid_rst_resp_v", resp_v_o, 1'b0);
    set_req(1'b0, 28'h600, 5'd1, 32'h0, 4'h0); #1;
    chk("mid_rst_ready", req_ready_o, 1'b1);
    req_v_i = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
